estabiliza_andar: RTL

ESTABILIZA_ANDAR -- requirements
Module: estabiliza_andar

---
 rtl/estabiliza_andar_if.sv | 26 ++
 rtl/estabiliza_andar.sv | 138 +++++++++++++
 2 files changed

// File: rtl/estabiliza_andar_if.sv
// Floor-stabiliser bus: detector samples and target requests in, confirmed floor and travel status out.
// Pure wiring, no latency; no backpressure (all inputs are one-cycle strobes).
// master drives the samples and requests; slave is the stabiliser.
interface estabiliza_andar_if;
  logic       pronto;
  logic [1:0] andar_in;
  logic [1:0] destino;
  logic       destino_valido;
  logic [1:0] andar_estavel;
  logic       estavel;
  logic       subindo;
  logic       descendo;
  logic       chegou;
  logic       ocupado;
  logic       erro_sensor;

  modport master (
    output pronto, andar_in, destino, destino_valido,
    input  andar_estavel, estavel, subindo, descendo, chegou, ocupado, erro_sensor
  );

  modport slave (
    input  pronto, andar_in, destino, destino_valido,
    output andar_estavel, estavel, subindo, descendo, chegou, ocupado, erro_sensor
  );
endinterface

// File: rtl/estabiliza_andar.sv
// Debounces floor samples into a confirmed floor and tracks travel to a target; ESTABILIZA_TIMEOUT_EN adds a sensor watchdog.
// Floor confirmed one edge after the CONFIRMA-th matching strobe; arrival flagged one cycle after confirmation.
// No backpressure: strobes are consumed on the cycle they arrive.
module estabiliza_andar #(
  parameter int CONFIRMA = 3,
  parameter int TIMEOUT  = 1000000
) (
  input logic          clock,
  input logic          reset,
  estabiliza_andar_if.slave bus
);

  if (CONFIRMA < 1 || CONFIRMA > 7 || TIMEOUT < 1) begin : g_bad_cfg
    $error("estabiliza_andar: CONFIRMA must be 1..7 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {LIVRE, MOVENDO, CHEGADA} estado_t;

  localparam logic [2:0] CONF = 3'(CONFIRMA);

  estado_t    estado;
  estado_t    estado_nxt;
  logic [1:0] cand;
  logic [2:0] cnt;
  logic [2:0] cnt_nxt;
  logic [1:0] andar_estavel;
  logic       estavel;
  logic [1:0] alvo;
  logic       timeout_hit;
  logic       subindo;
  logic       descendo;
  logic       chegou;
  logic       ocupado;

`ifdef ESTABILIZA_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);
  localparam logic [WDW-1:0] WD_PRE = WDW'(TIMEOUT - 1);

  logic [WDW-1:0] wd;
  logic           erro;

  assign timeout_hit = !bus.pronto && (wd == WD_PRE);

  always_ff @(posedge clock) begin
    if (reset) begin
      wd   <= '0;
      erro <= 1'b0;
    end else if (bus.pronto) begin
      wd   <= '0;
      erro <= 1'b0;
    end else begin
      if (wd != WD_MAX) wd <= wd + 1'b1;
      if (timeout_hit) erro <= 1'b1;
    end
  end

  assign bus.erro_sensor = erro;
`else
  assign timeout_hit     = 1'b0;
  assign bus.erro_sensor = 1'b0;
`endif

  always_comb begin
    cnt_nxt = cnt;
    if (bus.andar_in == cand) begin
      if (cnt < CONF) cnt_nxt = cnt + 3'd1;
    end else begin
      cnt_nxt = 3'd1;
    end
  end

  // A timeout also empties the run counter so estavel needs a full fresh confirmation.
  always_ff @(posedge clock) begin
    if (reset) begin
      cand          <= 2'd0;
      cnt           <= 3'd0;
      andar_estavel <= 2'd0;
      estavel       <= 1'b0;
    end else if (bus.pronto) begin
      cand <= bus.andar_in;
      cnt  <= cnt_nxt;
      if (cnt_nxt == CONF) begin
        andar_estavel <= bus.andar_in;
        estavel       <= 1'b1;
      end
    end else if (timeout_hit) begin
      cnt     <= 3'd0;
      estavel <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= LIVRE;
      alvo   <= 2'd0;
    end else begin
      estado <= estado_nxt;
      if (bus.destino_valido) alvo <= bus.destino;
    end
  end

  always_comb begin
    estado_nxt = estado;
    subindo    = 1'b0;
    descendo   = 1'b0;
    chegou     = 1'b0;
    ocupado    = 1'b0;
    case (estado)
      LIVRE: begin
        if (bus.destino_valido) estado_nxt = MOVENDO;
      end
      MOVENDO: begin
        ocupado = 1'b1;
        if (estavel) begin
          subindo  = alvo > andar_estavel;
          descendo = alvo < andar_estavel;
        end
        // A fresh request wins over an arrival seen in the same cycle.
        if (bus.destino_valido)                         estado_nxt = MOVENDO;
        else if (estavel && (andar_estavel == alvo))    estado_nxt = CHEGADA;
      end
      CHEGADA: begin
        chegou     = 1'b1;
        estado_nxt = bus.destino_valido ? MOVENDO : LIVRE;
      end
      default: estado_nxt = LIVRE;
    endcase
  end

  assign bus.andar_estavel = andar_estavel;
  assign bus.estavel       = estavel;
  assign bus.subindo       = subindo;
  assign bus.descendo      = descendo;
  assign bus.chegou        = chegou;
  assign bus.ocupado       = ocupado;

endmodule
